imem_arbiter: RTL

Shares the single dual-read instruction-memory port between the 2-wide fetch stage and the program loader, which writes program images and reads them back for checking. It sits between fetch and the instruction memory model. Each cycle it grants the port to one requester, tags the in-flight access, and routes the 1-cycle-latency response back to its owner. Responses belonging to a redirected fetch are dropped.

---
 rtl/imem_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - arbiter sharing the dual-read instruction-memory port between fetch and loader
//
// Purpose:
//    Each cycle grants the instruction-memory port to either the loader or the
//    2-wide fetch stage, remembers who owns the in-flight access, and routes the
//    1-cycle-latency read response back to that owner. The loader normally wins,
//    but after STARVE_MAX consecutive loader grants one cycle is reserved for
//    fetch. A fetch response arriving together with f_flush is discarded.
//
// Parameters:
//    XLEN        address/data width
//    STARVE_MAX  consecutive loader grants before a fetch-reserved cycle (1..15)
//
// Ports:
//    clk, reset_n                       clock, asynchronous active-low reset
//    f_ren, f_addr0, f_addr1, f_flush   fetch request, slot addresses, redirect
//    f_stall                            port taken by loader (independent of f_ren)
//    f_valid, f_rdata0, f_rdata1, f_pc  fetch response data and its addresses
//    ld_req, ld_we, ld_addr, ld_wdata   loader request / write / address / data
//    ld_gnt, ld_rvalid, ld_rdata        loader accept and read response
//    mem_en, mem_we, mem_addr0/1,
//    mem_wdata, mem_rdata0/1            memory port (read data 1 cycle after mem_en)
//
// Configuration:
//    IMEM_ARB_PERF_EN  when defined, adds saturating 32-bit counters
//                      perf_f_grants, perf_ld_grants, perf_stall_cycles, perf_flushed.

module imem_arbiter #(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 f_ren,
   input  logic [XLEN-1:0]      f_addr0,
   input  logic [XLEN-1:0]      f_addr1,
   input  logic                 f_flush,
   output logic                 f_stall,
   output logic                 f_valid,
   output logic [XLEN-1:0]      f_rdata0,
   output logic [XLEN-1:0]      f_rdata1,
   output logic [1:0][XLEN-1:0] f_pc,
   input  logic                 ld_req,
   input  logic                 ld_we,
   input  logic [XLEN-1:0]      ld_addr,
   input  logic [XLEN-1:0]      ld_wdata,
   output logic                 ld_gnt,
   output logic                 ld_rvalid,
   output logic [XLEN-1:0]      ld_rdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [XLEN-1:0]      mem_addr0,
   output logic [XLEN-1:0]      mem_addr1,
   output logic [XLEN-1:0]      mem_wdata,
   input  logic [XLEN-1:0]      mem_rdata0,
   input  logic [XLEN-1:0]      mem_rdata1
`ifdef IMEM_ARB_PERF_EN
   ,
   output logic [31:0]          perf_f_grants,
   output logic [31:0]          perf_ld_grants,
   output logic [31:0]          perf_stall_cycles,
   output logic [31:0]          perf_flushed
`endif
);

   typedef enum logic [1:0] {
      OWN_IDLE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2
   } owner_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic                 w_grant_ld;
   logic                 w_grant_f;
   logic [3:0]           r_starve_cnt;
   owner_t               r_owner;
   owner_t               w_owner_nxt;
   logic [1:0][XLEN-1:0] r_f_pc;

   // Loader priority is decided without looking at f_ren: fetch derives its
   // request from f_stall, so any dependency here would close a comb loop.
   always_comb begin
      w_grant_ld = ld_req && (r_starve_cnt != STARVE_LIM);
      w_grant_f  = f_ren && !w_grant_ld;
   end

   assign ld_gnt  = w_grant_ld;
   assign f_stall = w_grant_ld;

   // Memory is kept quiet while reset is asserted, even though the grant
   // outputs keep following the arbitration equations.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr0 = '0;
      mem_addr1 = '0;
      mem_wdata = '0;
      if (reset_n) begin
         if (w_grant_ld) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr0 = ld_addr;
            mem_addr1 = ld_addr + XLEN'(4);
            mem_wdata = ld_wdata;
         end else if (w_grant_f) begin
            mem_en    = 1'b1;
            mem_addr0 = f_addr0;
            mem_addr1 = f_addr1;
         end
      end
   end

   // Any cycle without a loader grant, including the reserved one left unused
   // by fetch, restarts the streak.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_starve_cnt <= '0;
      end else if (w_grant_ld) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
         r_starve_cnt <= '0;
      end
   end

   // Response owner: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_owner <= OWN_IDLE;
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   // Response owner: next state (loader writes return nothing)
   always_comb begin
      w_owner_nxt = OWN_IDLE;
      if (w_grant_f) begin
         w_owner_nxt = OWN_FETCH;
      end else if (w_grant_ld && !ld_we) begin
         w_owner_nxt = OWN_LOAD;
      end
   end

   // Response owner: outputs. A flush only masks the response; ownership
   // still moves on normally.
   always_comb begin
      f_valid   = 1'b0;
      ld_rvalid = 1'b0;
      case (r_owner)
         OWN_FETCH: f_valid   = !f_flush;
         OWN_LOAD:  ld_rvalid = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_f_pc <= '0;
      end else if (w_grant_f) begin
         r_f_pc[0] <= f_addr0;
         r_f_pc[1] <= f_addr1;
      end
   end

   assign f_pc     = r_f_pc;
   assign f_rdata0 = mem_rdata0;
   assign f_rdata1 = mem_rdata1;
   assign ld_rdata = mem_rdata0;

`ifdef IMEM_ARB_PERF_EN
   logic w_flushed;

   assign w_flushed = (r_owner == OWN_FETCH) && f_flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_f_grants     <= '0;
         perf_ld_grants    <= '0;
         perf_stall_cycles <= '0;
         perf_flushed      <= '0;
      end else begin
         if (w_grant_f && (perf_f_grants != '1)) begin
            perf_f_grants <= perf_f_grants + 32'd1;
         end
         if (w_grant_ld && (perf_ld_grants != '1)) begin
            perf_ld_grants <= perf_ld_grants + 32'd1;
         end
         if (w_grant_ld && f_ren && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
         if (w_flushed && (perf_flushed != '1)) begin
            perf_flushed <= perf_flushed + 32'd1;
         end
      end
   end
`endif

endmodule
